// File: rtl/minmax_window_acc.sv
// minmax_window_acc: reduces each multi-lane sample to min/max, accumulates extrema over a
// programmable window and emits MIN, MAX, MIN+MAX or MAX-MIN on a held valid/ready output.
module minmax_window_acc #(
    parameter int WIDTH = 32,
    parameter int NUM_CH = 4,
    parameter int MAX_WIN = 16,
    localparam int CW = $clog2(MAX_WIN + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [NUM_CH*WIDTH-1:0] in_data_i,
    input  logic [CW-1:0]           win_len_i,
    input  logic [1:0]              op_i,
    input  logic                    signed_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH:0]          out_data_o,
    output logic [CW-1:0]           out_count_o,
    output logic                    busy_o
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] len_q, len_d, cnt_q, cnt_d, out_cnt_q, out_cnt_d, len_in;
    logic [1:0] op_q, op_d;
    logic sgn_q, sgn_d, cur_sgn, hs, go_out;
    logic [WIDTH-1:0] acc_min_q, acc_min_d, acc_max_q, acc_max_d, smin, smax, lane;
    logic [WIDTH:0] out_data_q, out_data_d, ext_min, ext_max;

    function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        return s ? ($signed(a) < $signed(b)) : (a < b);
    endfunction

    assign in_ready_o  = state_q != OUT;
    assign busy_o      = state_q != IDLE;
    assign out_valid_o = state_q == OUT;
    assign out_data_o  = out_data_q;
    assign out_count_o = out_cnt_q;
    assign hs          = in_valid_i & in_ready_o;
    // The window's sign mode is only known once the first sample is taken.
    assign cur_sgn     = state_q == IDLE ? signed_i : sgn_q;
    assign len_in      = win_len_i == '0 ? CW'(1) : (win_len_i > CW'(MAX_WIN) ? CW'(MAX_WIN) : win_len_i);

    always_comb begin
        smin = in_data_i[WIDTH-1:0];
        smax = in_data_i[WIDTH-1:0];
        lane = '0;
        for (int k = 1; k < NUM_CH; k++) begin
            lane = in_data_i[k*WIDTH +: WIDTH];
            smin = lt(lane, smin, cur_sgn) ? lane : smin;
            smax = lt(smax, lane, cur_sgn) ? lane : smax;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        op_d      = op_q;
        sgn_d     = sgn_q;
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        cnt_d     = cnt_q;
        if (state_q == IDLE && hs) begin
            len_d     = len_in;
            op_d      = op_i;
            sgn_d     = signed_i;
            acc_min_d = smin;
            acc_max_d = smax;
            cnt_d     = CW'(1);
            state_d   = (len_in == CW'(1) || flush_i) ? OUT : ACC;
        end else if (state_q == ACC) begin
            if (hs) begin
                acc_min_d = lt(smin, acc_min_q, sgn_q) ? smin : acc_min_q;
                acc_max_d = lt(acc_max_q, smax, sgn_q) ? smax : acc_max_q;
                cnt_d     = cnt_q + CW'(1);
            end
            state_d = (flush_i || (hs && cnt_q + CW'(1) == len_q)) ? OUT : ACC;
        end else if (state_q == OUT && out_ready_i) begin
            state_d = IDLE;
        end
    end

    // Result is computed from the next-cycle accumulators so it is registered on entry to OUT.
    assign go_out     = state_d == OUT && state_q != OUT;
    assign ext_min    = {sgn_d & acc_min_d[WIDTH-1], acc_min_d};
    assign ext_max    = {sgn_d & acc_max_d[WIDTH-1], acc_max_d};
    assign out_cnt_d  = go_out ? cnt_d : out_cnt_q;
    assign out_data_d = !go_out ? out_data_q :
                        op_d == 2'd0 ? ext_min :
                        op_d == 2'd1 ? ext_max :
                        op_d == 2'd2 ? ext_min + ext_max : ext_max - ext_min;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            len_q      <= '0;
            op_q       <= '0;
            sgn_q      <= 1'b0;
            acc_min_q  <= '0;
            acc_max_q  <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            op_q       <= op_d;
            sgn_q      <= sgn_d;
            acc_min_q  <= acc_min_d;
            acc_max_q  <= acc_max_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
        end
    end
endmodule

// File: tb/tb_minmax_window_acc.sv
// tb_minmax_window_acc: directed table of single-sample windows plus hand-written multi-cycle sequences.
module tb_minmax_window_acc;
    localparam int W = 8;
    localparam int N = 4;
    localparam int CW = 5;

    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1, busy, sgn = 0;
    logic [N*W-1:0] in_data = '0;
    logic [CW-1:0] win_len = '0, out_count;
    logic [1:0] op = '0;
    logic [W:0] out_data;
    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  len;
        logic [1:0]  op;
        logic        sgn;
        logic [8:0]  exp_d;
        logic [4:0]  exp_c;
    } vec_t;
    vec_t tbl[13];

    minmax_window_acc #(.WIDTH(W), .NUM_CH(N), .MAX_WIN(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .win_len_i(win_len), .op_i(op), .signed_i(sgn), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_count_o(out_count), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic [31:0] d, input logic [4:0] l, input logic [1:0] o, input logic s, input logic [8:0] e, input logic [4:0] c);
        vec_t v;
        v.data = d; v.len = l; v.op = o; v.sgn = s; v.exp_d = e; v.exp_c = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] l, input logic [1:0] o, input logic s, input logic f);
        in_valid = 1; in_data = d; win_len = l; op = o; sgn = s; flush = f;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(pack(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 0, 1, 9'h180, 1);
        tbl[1]  = mk(pack(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 0, 0, 9'h000, 1);
        tbl[2]  = mk(pack(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 1, 1, 9'h07F, 1);
        tbl[3]  = mk(pack(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 1, 0, 9'h0FF, 1);
        tbl[4]  = mk(pack(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 2, 1, 9'h1FF, 1);
        tbl[5]  = mk(pack(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 2, 0, 9'h0FF, 1);
        tbl[6]  = mk(pack(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 3, 1, 9'h0FF, 1);
        tbl[7]  = mk(pack(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 3, 0, 9'h0FF, 1);
        tbl[8]  = mk(pack(8'd10, 8'd20, 8'd30, 8'd40), 0, 2, 0, 9'h032, 1);
        tbl[9]  = mk(pack(8'd10, 8'd20, 8'd30, 8'd40), 1, 3, 1, 9'h01E, 1);
        tbl[10] = mk(pack(8'hF0, 8'hF0, 8'hF0, 8'hF0), 1, 2, 1, 9'h1E0, 1);
        tbl[11] = mk(pack(8'hF0, 8'h10, 8'hF0, 8'hF0), 1, 0, 1, 9'h1F0, 1);
        tbl[12] = mk(pack(8'hF0, 8'h10, 8'hF0, 8'hF0), 1, 0, 0, 9'h010, 1);

        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_count", 32'(out_count), 0);
        rst_n = 1;
        tick(1);

        for (int i = 0; i < 13; i++) begin
            send(tbl[i].data, tbl[i].len, tbl[i].op, tbl[i].sgn, 0);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp_d));
            chk($sformatf("tbl%0d_count", i), 32'(out_count), 32'(tbl[i].exp_c));
            chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 0);
            tick(1);
            chk($sformatf("tbl%0d_done", i), 32'(out_valid), 0);
        end

        send(pack(8'd10, 8'd200, 8'd3, 8'd50), 2, 2, 0, 0);
        chk("add_mid_valid", 32'(out_valid), 0);
        chk("add_mid_busy", 32'(busy), 1);
        send(pack(8'd7, 8'd9, 8'd100, 8'd1), 2, 2, 0, 0);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_data", 32'(out_data), 201);
        chk("add_count", 32'(out_count), 2);
        tick(1);
        chk("add_ready_back", 32'(in_ready), 1);

        send(pack(8'h80, 8'h00, 8'h01, 8'h02), 3, 3, 1, 0);
        send(pack(8'h7F, 8'hFF, 8'h05, 8'h05), 3, 0, 0, 0);
        send(pack(8'h00, 8'h00, 8'h00, 8'h00), 7, 1, 0, 0);
        chk("range_valid", 32'(out_valid), 1);
        chk("range_data", 32'(out_data), 32'h0FF);
        chk("range_count", 32'(out_count), 3);
        tick(1);

        send(pack(8'd1, 8'd2, 8'd3, 8'd4), 5, 1, 0, 0);
        send(pack(8'd9, 8'd9, 8'd9, 8'd0), 5, 1, 0, 1);
        chk("flushhs_valid", 32'(out_valid), 1);
        chk("flushhs_data", 32'(out_data), 9);
        chk("flushhs_count", 32'(out_count), 2);
        tick(1);

        flush = 1;
        tick(1);
        flush = 0;
        chk("flush_idle_valid", 32'(out_valid), 0);
        chk("flush_idle_busy", 32'(busy), 0);

        send(pack(8'd6, 8'd2, 8'd3, 8'd4), 5, 0, 0, 0);
        flush = 1;
        tick(1);
        flush = 0;
        chk("flushacc_valid", 32'(out_valid), 1);
        chk("flushacc_data", 32'(out_data), 2);
        chk("flushacc_count", 32'(out_count), 1);
        tick(1);

        for (int i = 1; i <= 16; i++) begin
            send(pack(8'(i), 8'(i), 8'(i), 8'(i)), 20, 2, 0, 0);
            if (i == 15) chk("clamp_not_yet", 32'(out_valid), 0);
        end
        chk("clamp_valid", 32'(out_valid), 1);
        chk("clamp_data", 32'(out_data), 17);
        chk("clamp_count", 32'(out_count), 16);
        tick(1);

        out_ready = 0;
        send(pack(8'd5, 8'd5, 8'd5, 8'd5), 1, 1, 0, 0);
        in_valid = 1; in_data = pack(8'd77, 8'd77, 8'd77, 8'd77); win_len = 1; op = 1; sgn = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("bp%0d_data", i), 32'(out_data), 5);
            chk($sformatf("bp%0d_ready", i), 32'(in_ready), 0);
        end
        out_ready = 1;
        tick(1);
        chk("bp_rel_valid", 32'(out_valid), 0);
        chk("bp_rel_ready", 32'(in_ready), 1);
        tick(1);
        in_valid = 0;
        chk("bp_held_valid", 32'(out_valid), 1);
        chk("bp_held_data", 32'(out_data), 77);
        tick(1);

        for (int i = 0; i < 3; i++) send(pack(8'd250, 8'd250, 8'd250, 8'd250), 5, 2, 0, 0);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_count", 32'(out_count), 0);
        @(negedge clk);
        rst_n = 1;
        tick(1);
        send(pack(8'd1, 8'd1, 8'd1, 8'd1), 2, 2, 0, 0);
        send(pack(8'd2, 8'd2, 8'd2, 8'd2), 2, 2, 0, 0);
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_data", 32'(out_data), 3);
        chk("post_rst_count", 32'(out_count), 2);
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
